// File: rtl/bcd_subtractor_seq_if.sv
// Purpose: request/response bundle for the sequential packed-BCD subtractor.
// Latency: none (signal bundle only).
// Backpressure: none; start is only honoured while the subtractor is idle.
//
// Signals:
//   start   - request strobe, driven by the master
//   a, b    - minuend / subtrahend, packed BCD, digit 0 in [3:0]
//   bin     - borrow in
//   diff    - packed BCD result (registered)
//   bout    - borrow out (registered)
//   busy    - high while digits are being processed
//   done    - one-cycle completion pulse
//   invalid - last accepted request had a non-BCD digit
interface bcd_subtractor_seq_if #(
  parameter int DIGITS = 4
) ();
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  bin;
  logic [4*DIGITS-1:0]   diff;
  logic                  bout;
  logic                  busy;
  logic                  done;
  logic                  invalid;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done, invalid
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done, invalid
  );
endinterface

// File: rtl/bcd_subtractor_seq.sv
// Purpose: packed-BCD subtractor diff = a - b - bin, one decimal digit per clock, LSD first.
// Latency: done pulses DIGITS edges after the accepting edge (1 edge for non-BCD operands).
// Backpressure: start is ignored while busy or done; the requester re-presents it in idle.
//
// Ports:
//   i_clk    - rising-edge clock
//   i_rst_n  - asynchronous active-low reset
//   sub_if   - slave side of bcd_subtractor_seq_if (start/a/b/bin in, diff/bout/busy/done/invalid out)
module bcd_subtractor_seq #(
  parameter int DIGITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  bcd_subtractor_seq_if.slave  sub_if
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [W-1:0]       r_a;         // shifts right one digit per RUN cycle
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_diff;
  logic [IDX_W-1:0]   r_idx;
  logic               r_borrow;
  logic               r_bout;
  logic               r_invalid;
  logic               r_inv_pend;  // non-BCD request waiting one cycle before DONE

  logic               w_accept;
  logic               w_ops_bad;
  logic [4:0]         w_t;
  logic [3:0]         w_digit;
  logic               w_borrow_nxt;

  // Any operand digit above 9 marks the request invalid.
  always_comb begin
    w_ops_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((sub_if.a[4*i +: 4] > 4'd9) || (sub_if.b[4*i +: 4] > 4'd9)) begin
        w_ops_bad = 1'b1;
      end
    end
  end

  // Current digit: 5-bit two's complement difference; a negative result
  // borrows from the next digit and is brought back into range by +10
  // (the low nibble of t, plus 10, modulo 16).
  always_comb begin
    w_t          = {1'b0, r_a[3:0]} - {1'b0, r_b[3:0]} - {4'b0000, r_borrow};
    w_borrow_nxt = w_t[4];
    w_digit      = w_t[4] ? (w_t[3:0] + 4'd10) : w_t[3:0];
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state. An invalid request stays in IDLE for one extra cycle
  // (r_inv_pend) so it completes with the same timing as a one-digit
  // operation; start is not sampled during that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_inv_pend) begin
          w_state_nxt = S_DONE;
        end else if (sub_if.start) begin
          w_accept = 1'b1;
          if (!w_ops_bad) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_diff     <= '0;
      r_idx      <= '0;
      r_borrow   <= 1'b0;
      r_bout     <= 1'b0;
      r_invalid  <= 1'b0;
      r_inv_pend <= 1'b0;
    end else if (w_accept) begin
      r_a        <= sub_if.a;
      r_b        <= sub_if.b;
      r_diff     <= '0;
      r_idx      <= '0;
      r_borrow   <= w_ops_bad ? 1'b0 : sub_if.bin;
      r_bout     <= 1'b0;
      r_invalid  <= w_ops_bad;
      r_inv_pend <= w_ops_bad;
    end else if (r_state == S_RUN) begin
      r_diff[{r_idx, 2'b00} +: 4] <= w_digit;
      r_a      <= r_a >> 4;
      r_b      <= r_b >> 4;
      r_borrow <= w_borrow_nxt;
      r_idx    <= r_idx + 1'b1;
      if (r_idx == LAST_IDX) begin
        r_bout <= w_borrow_nxt;
      end
    end else if (r_state == S_IDLE) begin
      r_inv_pend <= 1'b0;
    end
  end

  assign sub_if.diff    = r_diff;
  assign sub_if.bout    = r_bout;
  assign sub_if.invalid = r_invalid;
  assign sub_if.busy    = (r_state == S_RUN);
  assign sub_if.done    = (r_state == S_DONE);

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Purpose: self-checking bench for bcd_subtractor_seq (decimal reference model + directed vectors).
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_subtractor_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  bcd_subtractor_seq_if #(.DIGITS(DIGITS)) sif ();

  bcd_subtractor_seq #(.DIGITS(DIGITS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .sub_if  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- decimal reference model ----------------
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic is_bad(input logic [W-1:0] v);
    logic bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Returns {bout, diff}.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int r = bcd2int(a) - bcd2int(b) - int'(bi);
    logic bo = 1'b0;
    if (r < 0) begin
      r  = r + 10 ** DIGITS;
      bo = 1'b1;
    end
    return {bo, int2bcd(r)};
  endfunction

  // Timing model: cycles remaining until the done cycle, plus the expected
  // held outputs of the most recently accepted request.
  int           m_left;
  logic         m_done;
  logic         m_inv;
  logic [W-1:0] e_diff;
  logic         e_bout;
  logic         e_inv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_inv  <= 1'b0;
      e_diff <= '0;
      e_bout <= 1'b0;
      e_inv  <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (sif.start) begin
      if (is_bad(sif.a) || is_bad(sif.b)) begin
        m_inv  <= 1'b1;
        e_inv  <= 1'b1;
        e_diff <= '0;
        e_bout <= 1'b0;
        m_left <= 1;
      end else begin
        m_inv  <= 1'b0;
        e_inv  <= 1'b0;
        {e_bout, e_diff} <= ref_sub(sif.a, sif.b, sif.bin);
        m_left <= DIGITS;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = (m_left != 0) && !m_inv;
    chk("model_busy", 32'(sif.busy), 32'(exp_busy));
    chk("model_done", 32'(sif.done), 32'(m_done));
    chk("model_invalid", 32'(sif.invalid), 32'(e_inv));
    if (!exp_busy) begin
      chk("model_diff", 32'(sif.diff), 32'(e_diff));
      chk("model_bout", 32'(sif.bout), 32'(e_bout));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input int exp_lat, input int exp_nbusy,
                       input logic [W-1:0] ed, input logic eb, input logic ei);
    int lat;
    int nb;
    bit seen;
    @(negedge clk);
    #1;
    sif.a = a; sif.b = b; sif.bin = bi; sif.start = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    lat = 0; nb = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sif.busy) nb++;
      if (sif.done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(nb), 32'(exp_nbusy));
    chk("diff", 32'(sif.diff), 32'(ed));
    chk("bout", 32'(sif.bout), 32'(eb));
    chk("invalid", 32'(sif.invalid), 32'(ei));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbi;
    logic [W:0]   rr;
    int           nd;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.bin = 1'b0;
    #1;
    chk("reset_diff", 32'(sif.diff), 32'h0);
    chk("reset_bout", 32'(sif.bout), 32'h0);
    chk("reset_busy", 32'(sif.busy), 32'h0);
    chk("reset_done", 32'(sif.done), 32'h0);
    chk("reset_invalid", 32'(sif.invalid), 32'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_op(16'h0500, 16'h0123, 1'b0, 4, 4, 16'h0377, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0, 4, 4, 16'h9999, 1'b1, 1'b0);
    do_op(16'h9999, 16'h9999, 1'b1, 4, 4, 16'h9999, 1'b1, 1'b0);
    do_op(16'h1000, 16'h0999, 1'b1, 4, 4, 16'h0000, 1'b0, 1'b0);
    do_op(16'h00A0, 16'h0001, 1'b0, 1, 0, 16'h0000, 1'b0, 1'b1);
    do_op(16'h0100, 16'h0001, 1'b0, 4, 4, 16'h0099, 1'b0, 1'b0);
    do_op(16'h1234, 16'h00F0, 1'b1, 1, 0, 16'h0000, 1'b0, 1'b1);
    do_op(16'h0001, 16'h0000, 1'b1, 4, 4, 16'h0000, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, 4, 4, 16'h9999, 1'b1, 1'b0);
    do_op(16'h9999, 16'h0000, 1'b0, 4, 4, 16'h9999, 1'b0, 1'b0);

    // start held high: one op per idle visit; a changed mid-run only
    // affects the next accepted request.
    @(negedge clk);
    #1;
    sif.a = 16'h1234; sif.b = 16'h0234; sif.bin = 1'b0; sif.start = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (sif.done) begin
        nd++;
        if (nd == 1) chk("held_diff1", 32'(sif.diff), 32'h1000);
        else         chk("held_diff2", 32'(sif.diff), 32'h9765);
      end
      if (k == 1) #1 sif.a = 16'h9999;
    end
    #1 sif.start = 1'b0;
    chk("held_done_count", 32'(nd), 32'd2);
    repeat (8) @(negedge clk);

    // Asynchronous reset in the second RUN cycle.
    @(negedge clk);
    #1;
    sif.a = 16'h5555; sif.b = 16'h1111; sif.bin = 1'b0; sif.start = 1'b1;
    @(posedge clk);
    #1 sif.start = 1'b0;
    @(posedge clk);
    #1 chk("rst_busy_before", 32'(sif.busy), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(sif.busy), 32'h0);
    chk("rst_done", 32'(sif.done), 32'h0);
    chk("rst_diff", 32'(sif.diff), 32'h0);
    chk("rst_bout", 32'(sif.bout), 32'h0);
    chk("rst_invalid", 32'(sif.invalid), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_op(16'h5555, 16'h1111, 1'b0, 4, 4, 16'h4444, 1'b0, 1'b0);

    // Sweep of valid operands against the decimal reference.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      rbi = 1'($urandom_range(0, 1));
      rr  = ref_sub(ra, rb, rbi);
      do_op(ra, rb, rbi, DIGITS, DIGITS, rr[W-1:0], rr[W], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
